// File: rtl/crc_net_pkg.sv
// Shared types and defaults for the CRC network controller transmit path.
package crc_net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_HDR,
    ST_DATA,
    ST_CRC,
    ST_IFG
  } tx_state_e;

  localparam logic [63:0] DEF_PREAMBLE = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [7:0]  DEF_SFD      = 8'hAB;
  localparam logic [7:0]  DEF_POLY     = 8'h07;

  // Width of the header length field for a given payload buffer depth.
  function automatic int len_w(input int max_bytes);
    return $clog2(max_bytes);
  endfunction

endpackage

// File: rtl/crc8_lfsr_serial.sv
// Bit-serial CRC-8, MSB-first; crc_next is the value the register takes at the next edge.
module crc8_lfsr_serial
  import crc_net_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = DEF_POLY,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] crc_out,
  output logic [7:0] crc_next
);

  logic [7:0] crc_q;
  logic [7:0] crc_upd;
  logic       fb;

  always_comb begin
    fb       = crc_q[7] ^ data_in;
    crc_upd  = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    crc_next = load ? CRC_INIT : (enable ? crc_upd : crc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_next;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/crc_tx_framer.sv
// Serial frame transmitter: preamble, SFD, header, payload, CRC-8, then a programmable gap.
module crc_tx_framer
  import crc_net_pkg::*;
#(
  parameter int          MAX_BYTES        = 16,
  parameter int          PREAMBLE_BITS    = 16,
  parameter logic [63:0] PREAMBLE_PATTERN = DEF_PREAMBLE,
  parameter logic [7:0]  SFD_PATTERN      = DEF_SFD,
  parameter logic [7:0]  CRC_POLY         = DEF_POLY,
  parameter logic [7:0]  CRC_INIT         = 8'h00,
  parameter bit          CRC_OVER_HDR     = 1'b0,
  parameter int          IFG_BITS         = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_header,
  input  logic [MAX_BYTES*8-1:0] in_payload,
  input  logic                   test_mode,
  input  logic                   abort,
  output logic                   tx_line,
  output logic                   tx_active,
  output logic                   frame_done,
  output logic                   aborted
);

  localparam int          LEN_W    = len_w(MAX_BYTES);
  localparam int          PW       = MAX_BYTES * 8;
  localparam logic [63:0] PRE_ALGN = PREAMBLE_PATTERN << (64 - PREAMBLE_BITS);
  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BITS - 1);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BITS - 1);

  tx_state_e   state_q, state_d, seg_next, after_crc;
  logic [10:0] cnt_q, cnt_d, seg_last;
  logic [10:0] data_last_q, data_last_d;
  logic [63:0] pre_sh_q, pre_sh_d;
  logic [7:0]  hdr_sh_q, hdr_sh_d;
  logic [PW-1:0] pay_sh_q, pay_sh_d;
  logic [7:0]  crc_sh_q, crc_sh_d;
  logic        tm_q, tm_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_active_q, tx_active_d;
  logic        frame_done_q, frame_done_d;
  logic        aborted_q, aborted_d;

  logic        in_frame, crc_load, crc_en, crc_din;
  logic [7:0]  crc_out, crc_next;

  assign in_ready  = (state_q == ST_IDLE);
  assign in_frame  = (state_q inside {ST_PRE, ST_SFD, ST_HDR, ST_DATA, ST_CRC});
  assign after_crc = (IFG_BITS == 0) ? ST_IDLE : ST_IFG;
  assign crc_load  = in_ready && in_valid;
  assign crc_en    = (state_q == ST_DATA) || (CRC_OVER_HDR && (state_q == ST_HDR));
  assign crc_din   = (state_q == ST_HDR) ? hdr_sh_q[7] : pay_sh_q[PW-1];

  crc8_lfsr_serial #(
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (crc_load),
    .enable   (crc_en),
    .data_in  (crc_din),
    .crc_out  (crc_out),
    .crc_next (crc_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_last_d  = data_last_q;
    pre_sh_d     = pre_sh_q;
    hdr_sh_d     = hdr_sh_q;
    pay_sh_d     = pay_sh_q;
    crc_sh_d     = crc_sh_q;
    tm_d         = tm_q;
    tx_line_d    = 1'b0;
    tx_active_d  = in_frame;
    frame_done_d = 1'b0;
    aborted_d    = 1'b0;
    seg_last     = '0;
    seg_next     = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pre_sh_d    = PRE_ALGN;
          hdr_sh_d    = in_header;
          pay_sh_d    = in_payload;
          data_last_d = 11'({in_header[LEN_W-1:0], 3'b111});
          tm_d        = test_mode;
          cnt_d       = '0;
          state_d     = ST_PRE;
        end
      end
      ST_PRE: begin
        tx_line_d = pre_sh_q[63];
        pre_sh_d  = {pre_sh_q[62:0], 1'b0};
        seg_last  = PRE_LAST;
        seg_next  = ST_SFD;
      end
      ST_SFD: begin
        tx_line_d = SFD_PATTERN[~cnt_q[2:0]];
        seg_last  = 11'd7;
        seg_next  = ST_HDR;
      end
      ST_HDR: begin
        tx_line_d = hdr_sh_q[7];
        hdr_sh_d  = {hdr_sh_q[6:0], 1'b0};
        seg_last  = 11'd7;
        seg_next  = ST_DATA;
      end
      ST_DATA: begin
        tx_line_d = pay_sh_q[PW-1] ^ (tm_q && (cnt_q == '0));
        pay_sh_d  = {pay_sh_q[PW-2:0], 1'b0};
        seg_last  = data_last_q;
        seg_next  = ST_CRC;
      end
      ST_CRC: begin
        // No CRC update happens in this state, so crc_out already equals crc_next.
        if (cnt_q == '0) begin
          tx_line_d = crc_next[7];
          crc_sh_d  = {crc_out[6:0], 1'b0};
        end else begin
          tx_line_d = crc_sh_q[7];
          crc_sh_d  = {crc_sh_q[6:0], 1'b0};
        end
        frame_done_d = (cnt_q == 11'd7);
        seg_last     = 11'd7;
        seg_next     = after_crc;
      end
      ST_IFG: begin
        seg_last = IFG_LAST;
        seg_next = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      if (cnt_q == seg_last) begin
        cnt_d   = '0;
        state_d = seg_next;
      end else begin
        cnt_d = cnt_q + 11'd1;
      end
    end

    if (abort && in_frame) begin
      tx_line_d    = 1'b0;
      tx_active_d  = 1'b0;
      frame_done_d = 1'b0;
      aborted_d    = 1'b1;
      cnt_d        = '0;
      state_d      = after_crc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_last_q  <= '0;
      pre_sh_q     <= '0;
      hdr_sh_q     <= '0;
      pay_sh_q     <= '0;
      crc_sh_q     <= '0;
      tm_q         <= 1'b0;
      tx_line_q    <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_last_q  <= data_last_d;
      pre_sh_q     <= pre_sh_d;
      hdr_sh_q     <= hdr_sh_d;
      pay_sh_q     <= pay_sh_d;
      crc_sh_q     <= crc_sh_d;
      tm_q         <= tm_d;
      tx_line_q    <= tx_line_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign tx_line    = tx_line_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_crc_tx_framer.sv
// Randomised and directed checks of crc_tx_framer against a byte-level frame model.
module tb_crc_tx_framer;

  localparam int          MAX_BYTES = 16;
  localparam int          PW        = MAX_BYTES * 8;
  localparam int          PB        = 16;
  localparam logic [63:0] PRE_PAT   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [7:0]  SFD       = 8'hAB;
  localparam logic [7:0]  POLY      = 8'h07;
  localparam logic [7:0]  INIT      = 8'h00;
  localparam bit          OVER_HDR  = 1'b0;
  localparam int          IFG       = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_header = '0;
  logic [PW-1:0] in_payload = '0;
  logic          test_mode = 1'b0;
  logic          abort = 1'b0;
  logic          tx_line, tx_active, frame_done, aborted;

  int n_chk = 0;
  int n_fail = 0;

  crc_tx_framer #(
    .MAX_BYTES        (MAX_BYTES),
    .PREAMBLE_BITS    (PB),
    .PREAMBLE_PATTERN (PRE_PAT),
    .SFD_PATTERN      (SFD),
    .CRC_POLY         (POLY),
    .CRC_INIT         (INIT),
    .CRC_OVER_HDR     (OVER_HDR),
    .IFG_BITS         (IFG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_header  (in_header),
    .in_payload (in_payload),
    .test_mode  (test_mode),
    .abort      (abort),
    .tx_line    (tx_line),
    .tx_active  (tx_active),
    .frame_done (frame_done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  // Expected line content of one whole frame, right-aligned, plus its length in bits.
  task automatic model(input logic [7:0] hdr, input logic [PW-1:0] pay, input bit tm,
                       output logic [255:0] v, output int n);
    bit          q[$];
    logic [7:0]  by[$];
    logic [7:0]  c;
    logic [63:0] pp;
    int          len;
    pp  = PRE_PAT;
    len = int'(hdr) % MAX_BYTES + 1;
    for (int i = PB - 1; i >= 0; i--) q.push_back(pp[i]);
    by.push_back(SFD);
    by.push_back(hdr);
    for (int j = 0; j < len; j++) by.push_back(pay[PW-1-8*j -: 8]);
    c = INIT;
    if (OVER_HDR) c = crc_byte(c, hdr);
    for (int j = 0; j < len; j++) c = crc_byte(c, by[2+j]);
    by.push_back(c);
    if (tm) by[2] = by[2] ^ 8'h80;
    foreach (by[k]) for (int i = 7; i >= 0; i--) q.push_back(by[k][i]);
    v = '0;
    foreach (q[k]) v = {v[254:0], q[k]};
    n = q.size();
  endtask

  function automatic logic [PW-1:0] rand_pay();
    logic [PW-1:0] p;
    for (int i = 0; i < MAX_BYTES; i++) p[8*i +: 8] = 8'($urandom);
    return p;
  endfunction

  // Send one frame (optionally aborted after ab_at line bits) and check it through the gap.
  task automatic run_frame(input logic [7:0] hdr, input logic [PW-1:0] pay, input bit tm,
                           input int ab_at, output logic [255:0] obs, output int nact);
    logic [255:0] expv;
    int en, ndone, done_at, nab, ab_pos, gap_bad, rdy, inact, k;
    bit fired, ended;
    model(hdr, pay, tm, expv, en);
    if (ab_at >= 0) begin
      expv = expv >> (en - ab_at);
      en   = ab_at;
    end
    k = 0;
    while (!in_ready && k < 400) begin @(negedge clk); k++; end
    chk("ready_before_frame", 256'(in_ready), 256'(1));
    in_valid = 1'b1; in_header = hdr; in_payload = pay; test_mode = tm;
    @(negedge clk);
    in_valid = 1'b0; in_payload = ~pay; test_mode = ~tm;
    obs = '0; nact = 0; ndone = 0; done_at = 0; nab = 0; ab_pos = 0;
    gap_bad = 0; rdy = 0; inact = 0; fired = 0; ended = 0;
    for (int c = 0; c < 500 && !ended; c++) begin
      if (ab_at >= 0 && !fired && nact == ab_at) begin abort = 1'b1; fired = 1; end
      @(negedge clk);
      abort = 1'b0;
      if (tx_active) begin obs = {obs[254:0], tx_line}; nact++; end
      if (frame_done) begin ndone++; done_at = nact; end
      if (!tx_active && nact > 0) begin
        inact++;
        if (tx_line) gap_bad++;
        if (in_ready) begin rdy = inact; ended = 1; end
      end
      if (aborted) begin nab++; ab_pos = inact; end
    end
    chk("frame_end_seen", 256'(ended), 256'(1));
    chk("line_bits", obs, expv);
    chk("active_len", 256'(nact), 256'(en));
    chk("gap_line_zero", 256'(gap_bad), 256'(0));
    if (ab_at >= 0) begin
      chk("abort_done_cnt", 256'(ndone), 256'(0));
      chk("abort_pulse_cnt", 256'(nab), 256'(1));
      chk("abort_pulse_pos", 256'(ab_pos), 256'(1));
      chk("abort_ready_gap", 256'(rdy), 256'(IFG + 1));
    end else begin
      chk("done_cnt", 256'(ndone), 256'(1));
      chk("done_pos", 256'(done_at), 256'(en));
      chk("aborted_cnt", 256'(nab), 256'(0));
      chk("ready_gap", 256'(rdy), 256'(IFG));
    end
  endtask

  initial begin
    logic [255:0]  obs, expv;
    logic [PW-1:0] pay;
    logic [7:0]    hdr;
    int            nact, en, ab, runs, gap, n2, na, k;
    bit            prev, a;

    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(in_ready), 256'(1));
    chk("rst_line", 256'(tx_line), 256'(0));
    chk("rst_active", 256'(tx_active), 256'(0));
    chk("rst_done", 256'(frame_done), 256'(0));
    chk("rst_aborted", 256'(aborted), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Minimal frame: one payload byte 0x01.
    pay = rand_pay(); pay[PW-1 -: 8] = 8'h01;
    run_frame(8'h00, pay, 1'b0, -1, obs, nact);
    chk("min_frame_line", obs, 256'h0000_AAAA_AB00_0107);
    chk("min_frame_len", 256'(nact), 256'(48));

    // CRC-8 check value over "123456789".
    pay = rand_pay(); pay[PW-1 -: 72] = "123456789";
    run_frame(8'h08, pay, 1'b0, -1, obs, nact);
    chk("check_crc", 256'(obs[7:0]), 256'(8'hF4));
    chk("check_len", 256'(nact), 256'(112));

    // in_valid held: two frames separated by exactly IFG+1 zero cycles.
    hdr = 8'h02; pay = rand_pay();
    model(hdr, pay, 1'b0, expv, en);
    in_valid = 1'b1; in_header = hdr; in_payload = pay; test_mode = 1'b0;
    runs = 0; gap = 0; n2 = 0; prev = 0; obs = '0;
    for (int c = 0; c < 600 && !(runs == 2 && !prev && n2 > 0); c++) begin
      @(negedge clk);
      a = tx_active;
      if (a && !prev) begin runs++; if (runs == 2) in_valid = 1'b0; end
      if (!a && runs == 1) gap++;
      if (a && runs == 2) begin obs = {obs[254:0], tx_line}; n2++; end
      prev = a;
    end
    in_valid = 1'b0;
    chk("b2b_gap", 256'(gap), 256'(IFG + 1));
    chk("b2b_second_line", obs, expv);
    chk("b2b_second_len", 256'(n2), 256'(en));

    // Test mode flips only the first payload bit on the line.
    pay = rand_pay(); pay[PW-1 -: 8] = 8'h01;
    run_frame(8'h00, pay, 1'b1, -1, obs, nact);
    chk("tm_line", obs, 256'h0000_AAAA_AB00_8107);

    // Abort on the third payload cycle.
    run_frame(8'h05, rand_pay(), 1'b0, PB + 16 + 2, obs, nact);

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", 256'(in_ready), 256'(1));
    chk("idle_abort_pulse", 256'(aborted), 256'(0));

    // Reset mid-payload, then a clean frame.
    in_valid = 1'b1; in_header = 8'h03; in_payload = rand_pay();
    @(negedge clk);
    in_valid = 1'b0;
    na = 0; k = 0;
    while (na < PB + 20 && k < 200) begin
      @(negedge clk);
      if (tx_active) na++;
      k++;
    end
    chk("pre_reset_active", 256'(tx_active), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_active", 256'(tx_active), 256'(0));
    chk("mid_rst_line", 256'(tx_line), 256'(0));
    chk("mid_rst_ready", 256'(in_ready), 256'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'($urandom), rand_pay(), 1'b0, -1, obs, nact);

    // Random frames, some aborted at a random bit.
    for (int i = 0; i < 10; i++) begin
      hdr = 8'($urandom);
      pay = rand_pay();
      a   = 1'($urandom);
      model(hdr, pay, a, expv, en);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, en - 1)) : -1;
      run_frame(hdr, pay, a, ab, obs, nact);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
